game_session_keeper: RTL and testbench

- Responder end of the new-game handshake: receives new_game_request and grants it with new_game_in_progress.
- Owns the 128 x 11 object memory and accepts the board copy-in stream (address_write_om / data_write_om / wren).
- After new_game_ready, scans the loaded board, counts occupied cells, then re-enables the game engine.
- Sits between the new-game coordinator, the game engine and the display reader.

---
 rtl/game_session_keeper_pkg.sv | 35 +++
 rtl/game_session_keeper_object_memory.sv | 33 +++
 rtl/game_session_keeper.sv | 197 +++++++++++++++++++
 tb/tb_game_session_keeper.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_session_keeper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_session_keeper_pkg
//  Description : Shared types and constants for the new-game session keeper:
//                FSM state encoding, object-memory geometry, board size.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_session_keeper_pkg;

  localparam int OM_ADDR_W     = 7;
  localparam int OM_DATA_W     = 11;
  localparam int OM_DEPTH      = 1 << OM_ADDR_W;
  localparam int BOARD_CELLS   = 104;
  localparam int GRANT_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_GRANTED = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_SCAN    = 3'd4
  } state_t;

  // Externally visible state code; DRAIN is reported as IDLE.
  function automatic logic [1:0] state_leds(input state_t s);
    case (s)
      ST_GRANTED: return 2'd1;
      ST_SETTLE:  return 2'd2;
      ST_SCAN:    return 2'd3;
      default:    return 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_session_keeper_object_memory.sv
`default_nettype none
// ============================================================================
//  Module      : game_session_keeper_object_memory
//  Description : Object memory, one write port and two independent
//                synchronous read ports (display and scan). Not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_session_keeper_object_memory
  import game_session_keeper_pkg::*;
(
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [OM_ADDR_W-1:0] wr_addr,
  input  logic [OM_DATA_W-1:0] wr_data,
  input  logic [OM_ADDR_W-1:0] rd_addr_a,
  output logic [OM_DATA_W-1:0] rd_data_a,
  input  logic [OM_ADDR_W-1:0] rd_addr_b,
  output logic [OM_DATA_W-1:0] rd_data_b
);

  logic [OM_DATA_W-1:0] mem [0:OM_DEPTH-1];

  // Single write port plus two registered reads (read-before-write).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_a <= mem[rd_addr_a];
    rd_data_b <= mem[rd_addr_b];
  end

endmodule
`default_nettype wire

// File: rtl/game_session_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : game_session_keeper
//  Description : Responder side of the new-game handshake. Grants the
//                coordinator access to the object memory, accepts the board
//                copy-in, then scans the board and counts occupied cells
//                before handing the memory back to the game engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_session_keeper
  import game_session_keeper_pkg::*;
#(
  parameter int BOARD_CELLS   = game_session_keeper_pkg::BOARD_CELLS,
  parameter int GRANT_TIMEOUT = game_session_keeper_pkg::GRANT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 new_game_request,
  output logic                 new_game_in_progress,
  input  logic                 resetting,
  input  logic                 new_game_ready,
  input  logic [OM_ADDR_W-1:0] address_write_om,
  input  logic [OM_DATA_W-1:0] data_write_om,
  input  logic                 wren,
  input  logic                 engine_busy,
  input  logic [OM_ADDR_W-1:0] engine_address,
  input  logic [OM_DATA_W-1:0] engine_data,
  input  logic                 engine_wren,
  output logic                 engine_enable,
  input  logic [OM_ADDR_W-1:0] address_read,
  output logic [OM_DATA_W-1:0] data_read,
  output logic [6:0]           piece_count,
  output logic                 board_ready,
  output logic                 grant_error,
  output logic [1:0]           leds
);

  localparam int SCAN_W = $clog2(BOARD_CELLS + 1);
  localparam int TMO_W  = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(BOARD_CELLS);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(GRANT_TIMEOUT - 1);

  state_t               state_q;
  state_t               state_d;
  logic                 pending;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [SCAN_W-1:0]    scan_cnt;
  logic [6:0]           acc;
  logic                 mem_we;
  logic [OM_ADDR_W-1:0] mem_waddr;
  logic [OM_DATA_W-1:0] mem_wdata;
  logic [OM_DATA_W-1:0] scan_data;
  logic                 scan_hit;
  logic                 scan_last;
  logic                 enter_granted;
  logic                 timeout_hit;
  logic                 req_seen;

  // A request in the current cycle is served immediately, not a cycle later.
  assign req_seen      = pending | new_game_request;
  assign enter_granted = (state_d == ST_GRANTED) && (state_q != ST_GRANTED);
  assign scan_hit      = (scan_data != '0);
  assign scan_last     = (state_q == ST_SCAN) && (scan_cnt == SCAN_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, handshake outputs and write-port source selection.
  always_comb begin
    state_d              = state_q;
    new_game_in_progress = 1'b0;
    engine_enable        = 1'b0;
    timeout_hit          = 1'b0;
    mem_we               = 1'b0;
    mem_waddr            = engine_address;
    mem_wdata            = engine_data;
    leds                 = state_leds(state_q);
    case (state_q)
      ST_IDLE: begin
        engine_enable = 1'b1;
        mem_we        = engine_wren;
        if (req_seen) begin
          state_d = engine_busy ? ST_DRAIN : ST_GRANTED;
        end
      end
      ST_DRAIN: begin
        mem_we = engine_wren;
        if (!engine_busy) begin
          state_d = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        new_game_in_progress = 1'b1;
        mem_we               = wren;
        mem_waddr            = address_write_om;
        mem_wdata            = data_write_om;
        if (new_game_ready) begin
          state_d = ST_SETTLE;
        end else if (!resetting && (tmo_cnt == TMO_LAST)) begin
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        // Coordinator wren trails new_game_ready by one cycle.
        mem_we    = wren;
        mem_waddr = address_write_om;
        mem_wdata = data_write_om;
        state_d   = ST_SCAN;
      end
      ST_SCAN: begin
        if (scan_last) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pending request flag; a request also survives a coincident reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= new_game_request;
    end else if (enter_granted) begin
      pending <= 1'b0;
    end else if (new_game_request) begin
      pending <= 1'b1;
    end
  end

  // Grant watchdog: counts idle GRANTED cycles, reloaded by coordinator activity.
  always_ff @(posedge clk) begin
    if (reset || (state_q != ST_GRANTED) || resetting) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Sticky grant error, cleared when the next grant begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_error <= 1'b0;
    end else if (timeout_hit) begin
      grant_error <= 1'b1;
    end else if (enter_granted) begin
      grant_error <= 1'b0;
    end
  end

  // Scan address counter and occupancy accumulator (data lags address by one).
  always_ff @(posedge clk) begin
    if (reset || (state_q != ST_SCAN)) begin
      scan_cnt <= '0;
      acc      <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      if (scan_cnt != '0) begin
        acc <= acc + 7'(scan_hit);
      end
    end
  end

  // Publish the count and pulse board_ready after the last data word.
  always_ff @(posedge clk) begin
    if (reset) begin
      piece_count <= '0;
      board_ready <= 1'b0;
    end else begin
      board_ready <= scan_last;
      if (scan_last) begin
        piece_count <= acc + 7'(scan_hit);
      end
    end
  end

  game_session_keeper_object_memory u_object_memory (
    .clk       (clk),
    .wr_en     (mem_we),
    .wr_addr   (mem_waddr),
    .wr_data   (mem_wdata),
    .rd_addr_a (address_read),
    .rd_data_a (data_read),
    .rd_addr_b (OM_ADDR_W'(scan_cnt)),
    .rd_data_b (scan_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_game_session_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_session_keeper
//  Description : Directed self-checking bench for game_session_keeper.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_session_keeper;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_game_request;
  logic        new_game_in_progress;
  logic        resetting;
  logic        new_game_ready;
  logic [6:0]  address_write_om;
  logic [10:0] data_write_om;
  logic        wren;
  logic        engine_busy;
  logic [6:0]  engine_address;
  logic [10:0] engine_data;
  logic        engine_wren;
  logic        engine_enable;
  logic [6:0]  address_read;
  logic [10:0] data_read;
  logic [6:0]  piece_count;
  logic        board_ready;
  logic        grant_error;
  logic [1:0]  leds;

  int checks = 0;
  int errors = 0;
  int lat;

  game_session_keeper dut (
    .clk                  (clk),
    .reset                (reset),
    .new_game_request     (new_game_request),
    .new_game_in_progress (new_game_in_progress),
    .resetting            (resetting),
    .new_game_ready       (new_game_ready),
    .address_write_om     (address_write_om),
    .data_write_om        (data_write_om),
    .wren                 (wren),
    .engine_busy          (engine_busy),
    .engine_address       (engine_address),
    .engine_data          (engine_data),
    .engine_wren          (engine_wren),
    .engine_enable        (engine_enable),
    .address_read         (address_read),
    .data_read            (data_read),
    .piece_count          (piece_count),
    .board_ready          (board_ready),
    .grant_error          (grant_error),
    .leds                 (leds)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; inputs change and outputs are sampled 1ns after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [10:0] pat(input int mode, input int a);
    logic [6:0] a7;
    a7 = 7'(a);
    if (mode == 0) return (a % 2 == 0) ? 11'h001 : 11'h000;
    return (a % 4 == 3) ? {4'hA, a7} : 11'h000;
  endfunction

  // Writes addresses 0..104; ready rides with address 103, address 104 lands
  // in SETTLE. Returns two cycles after the ready cycle (first SCAN cycle).
  task automatic load_board(input int mode);
    resetting = 1'b1;
    wren      = 1'b1;
    for (int a = 0; a <= 104; a++) begin
      address_write_om = 7'(a);
      data_write_om    = pat(mode, a);
      new_game_ready   = (a == 103);
      step(1);
    end
    wren           = 1'b0;
    resetting      = 1'b0;
    new_game_ready = 1'b0;
  endtask

  // Counts cycles since the ready cycle until board_ready, bounded.
  task automatic wait_board(input int start, output int n);
    n = start;
    while (!board_ready && n < 400) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; new_game_request = 1'b0; resetting = 1'b0; new_game_ready = 1'b0;
    address_write_om = '0; data_write_om = '0; wren = 1'b0; engine_busy = 1'b0;
    engine_address = '0; engine_data = '0; engine_wren = 1'b0; address_read = '0;
    #1;
    step(3);
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_grant", 32'(new_game_in_progress), 32'd0);
    check("rst_engine_en", 32'(engine_enable), 32'd1);
    check("rst_piece_count", 32'(piece_count), 32'd0);
    check("rst_board_ready", 32'(board_ready), 32'd0);
    check("rst_grant_error", 32'(grant_error), 32'd0);

    // Request in the same cycle as reset is remembered.
    new_game_request = 1'b1;
    step(1);
    reset = 1'b0; new_game_request = 1'b0;
    check("rstreq_idle_grant", 32'(new_game_in_progress), 32'd0);
    step(1);
    check("rstreq_grant", 32'(new_game_in_progress), 32'd1);
    check("rstreq_leds", 32'(leds), 32'd1);
    check("rstreq_engine_en", 32'(engine_enable), 32'd0);

    // Load, then reset at scan address 50.
    load_board(0);
    check("scan_leds", 32'(leds), 32'd3);
    check("scan_engine_en", 32'(engine_enable), 32'd0);
    step(50);
    check("scan50_leds", 32'(leds), 32'd3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("midscan_rst_leds", 32'(leds), 32'd0);
    check("midscan_rst_engine_en", 32'(engine_enable), 32'd1);
    check("midscan_rst_piece_count", 32'(piece_count), 32'd0);
    check("midscan_rst_board_ready", 32'(board_ready), 32'd0);
    step(1);
    check("midscan_rst_stays_idle", 32'(leds), 32'd0);

    // Full load with engine idle: 52 occupied cells.
    new_game_request = 1'b1;
    step(1);
    new_game_request = 1'b0;
    check("req_grant_next_cycle", 32'(new_game_in_progress), 32'd1);
    load_board(0);
    wait_board(2, lat);
    check("board_ready_latency_a", 32'(lat), 32'd107);
    check("piece_count_a", 32'(piece_count), 32'd52);
    step(1);
    check("board_ready_one_cycle", 32'(board_ready), 32'd0);
    check("post_scan_leds", 32'(leds), 32'd0);
    check("post_scan_engine_en", 32'(engine_enable), 32'd1);
    address_read = 7'd104;
    step(1);
    check("settle_write_landed", 32'(data_read), 32'h001);

    // Engine busy for 5 cycles when the request arrives.
    engine_busy = 1'b1; new_game_request = 1'b1;
    step(1);
    new_game_request = 1'b0;
    check("drain_leds", 32'(leds), 32'd0);
    check("drain_engine_en", 32'(engine_enable), 32'd0);
    check("drain_no_grant", 32'(new_game_in_progress), 32'd0);
    engine_wren = 1'b1; engine_address = 7'd5; engine_data = 11'h155;
    step(1);
    engine_wren = 1'b0;
    step(2);
    check("drain_still_waiting", 32'(new_game_in_progress), 32'd0);
    step(1);
    engine_busy = 1'b0;
    check("busy_fall_no_grant_yet", 32'(new_game_in_progress), 32'd0);
    step(1);
    check("grant_after_busy", 32'(new_game_in_progress), 32'd1);
    engine_wren = 1'b1; engine_address = 7'd6; engine_data = 11'h2AA;
    step(1);
    engine_wren = 1'b0;
    address_read = 7'd5;
    step(1);
    check("drain_engine_write", 32'(data_read), 32'h155);
    address_read = 7'd6;
    step(1);
    check("granted_engine_write_dropped", 32'(data_read), 32'h001);

    // Second pattern; display read during scan.
    load_board(1);
    address_read = 7'd7;
    step(1);
    check("display_read_in_scan", 32'(data_read), 32'h507);
    check("display_read_scan_leds", 32'(leds), 32'd3);
    wait_board(3, lat);
    check("board_ready_latency_b", 32'(lat), 32'd107);
    check("piece_count_b", 32'(piece_count), 32'd26);

    // Grant timeout with no coordinator activity.
    step(2);
    new_game_request = 1'b1;
    step(1);
    new_game_request = 1'b0;
    check("tmo_grant", 32'(new_game_in_progress), 32'd1);
    step(1022);
    check("tmo_last_granted_cycle", 32'(leds), 32'd1);
    check("tmo_no_error_yet", 32'(grant_error), 32'd0);
    step(1);
    check("tmo_leds_idle", 32'(leds), 32'd0);
    check("tmo_grant_error", 32'(grant_error), 32'd1);
    check("tmo_grant_dropped", 32'(new_game_in_progress), 32'd0);
    check("tmo_engine_en", 32'(engine_enable), 32'd1);
    step(3);
    check("tmo_error_sticky", 32'(grant_error), 32'd1);
    new_game_request = 1'b1;
    step(1);
    new_game_request = 1'b0;
    check("regrant", 32'(new_game_in_progress), 32'd1);
    check("regrant_clears_error", 32'(grant_error), 32'd0);
    new_game_ready = 1'b1;
    step(1);
    new_game_ready = 1'b0;
    check("settle_leds", 32'(leds), 32'd2);
    check("settle_grant_low", 32'(new_game_in_progress), 32'd0);
    step(1);
    wait_board(2, lat);
    check("board_ready_latency_c", 32'(lat), 32'd107);
    check("piece_count_c", 32'(piece_count), 32'd26);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
